// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    localparam int unsigned PC_W_DEF  = 9;
    localparam int unsigned INS_W_DEF = 32;
    localparam int unsigned PC_STEP   = 4;
    localparam int unsigned RESET_PC  = 0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]  pc;
        logic [INS_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect port and decode handshake.
// if_fault exists only when IF_MISALIGN_TRAP_EN is defined.
interface if_fetch_unit_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             id_ready;
    logic             if_valid;
    logic [INS_W-1:0] if_instr;
    logic [PC_W-1:0]  if_pc;
    logic [PC_W-1:0]  if_pcplus4;
`ifdef IF_MISALIGN_TRAP_EN
    logic             if_fault;
`endif

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pcplus4,
`ifdef IF_MISALIGN_TRAP_EN
        output if_fault,
`endif
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pcplus4,
`ifdef IF_MISALIGN_TRAP_EN
        input  if_fault,
`endif
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Circular prefetch buffer of fetch entries with flush, count and head read.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage is cleared on reset so the head read shows a zero entry out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= ptr_next(tail_q);
            end
            if (pop_i) head_q <= ptr_next(head_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, issue/kill control and prefetch buffer feeding decode.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirects raise if_fault and halt fetch.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    if_fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_pc_q;
    logic            inflight_q;
    logic            kill_q;
    logic [PC_W-1:0] redirect_tgt;
    logic            halted;

    entry_t          head, push_data;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            push, pop, issue, valid;

`ifdef IF_MISALIGN_TRAP_EN
    logic halted_q;
    assign halted       = halted_q;
    assign redirect_tgt = bus.redirect_pc;
    assign bus.if_fault = halted_q;
`else
    assign halted       = 1'b0;
    assign redirect_tgt = {bus.redirect_pc[PC_W-1:2], 2'b00};
`endif

    assign valid     = (count != '0);
    assign pop       = valid & bus.id_ready & ~bus.redirect_valid;
    assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue     = ~reset & ~bus.redirect_valid & ~halted & (occupancy < (CW+1)'(DEPTH));
    // The word arriving in a redirect cycle, or one marked killed, belongs to the old stream.
    assign push      = inflight_q & ~kill_q & ~bus.redirect_valid;
    assign push_data = '{pc: req_pc_q, instr: bus.imem_rdata};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) fetch_pc_d = redirect_tgt;
        else if (issue)         fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= PC_W'(RESET_PC);
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            kill_q     <= bus.redirect_valid & inflight_q;
            if (issue) req_pc_q <= fetch_pc_q;
`ifdef IF_MISALIGN_TRAP_EN
            if (bus.redirect_valid) halted_q <= |bus.redirect_pc[1:0];
`endif
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .flush_i     (bus.redirect_valid),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.if_valid   = valid;
    assign bus.if_instr   = head.instr;
    assign bus.if_pc      = head.pc;
    assign bus.if_pcplus4 = head.pc + PC_W'(PC_STEP);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, backpressure, redirects, PC wrap, misaligned target.
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    if_fetch_unit_if #(.PC_W(9), .INS_W(32)) bus();

    if_fetch_unit #(.PC_W(9), .INS_W(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    // Synchronous-read instruction memory: word for address a returns the cycle after the request.
    always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= word(bus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        reset              = 1'b1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) nxt();
        #1;
        chk("rst_req",    bus.imem_req,   0);
        chk("rst_valid",  bus.if_valid,   0);
        chk("rst_instr",  bus.if_instr,   0);
        chk("rst_pc",     bus.if_pc,      0);
        chk("rst_pc4",    bus.if_pcplus4, 4);
`ifdef IF_MISALIGN_TRAP_EN
        chk("rst_fault",  bus.if_fault,   0);
`endif

        // Streaming with id_ready high
        nxt(); reset = 1'b0; #1;
        chk("c0_req",  bus.imem_req,  1);
        chk("c0_addr", bus.imem_addr, 0);
        nxt(); #1;
        chk("c1_addr",  bus.imem_addr, 4);
        chk("c1_valid", bus.if_valid,  0);
        nxt(); #1;
        chk("c2_valid", bus.if_valid,   1);
        chk("c2_pc",    bus.if_pc,      0);
        chk("c2_pc4",   bus.if_pcplus4, 4);
        chk("c2_instr", bus.if_instr,   word(9'h000));
        chk("c2_addr",  bus.imem_addr,  8);
        nxt(); #1;
        chk("c3_pc",    bus.if_pc,      4);
        chk("c3_pc4",   bus.if_pcplus4, 8);
        chk("c3_instr", bus.if_instr,   word(9'h004));
        nxt(); #1;
        chk("c4_pc",    bus.if_pc,      8);

        // Asynchronous reset mid-stream, then backpressure
        reset = 1'b1; #1;
        chk("arst_valid", bus.if_valid, 0);
        chk("arst_req",   bus.imem_req, 0);
        nxt(); reset = 1'b0; #1;
        chk("bp0_addr", bus.imem_addr, 0);
        nxt(); bus.id_ready = 1'b0; #1;
        chk("bp1_addr", bus.imem_addr, 4);
        nxt(); #1;
        chk("bp2_req",   bus.imem_req, 0);
        chk("bp2_valid", bus.if_valid, 1);
        chk("bp2_pc",    bus.if_pc,    0);
        nxt(); #1;
        chk("bp3_req",   bus.imem_req, 0);
        chk("bp3_pc",    bus.if_pc,    0);
        nxt(); #1;
        chk("bp4_req",   bus.imem_req, 0);
        chk("bp4_pc",    bus.if_pc,    0);
        bus.id_ready = 1'b1; #1;
        chk("bp4r_req",  bus.imem_req,  1);
        chk("bp4r_addr", bus.imem_addr, 8);
        nxt(); #1;
        chk("bp5_pc",   bus.if_pc,     4);
        chk("bp5_addr", bus.imem_addr, 12);

        // Redirect to 0x40 while the PC 8 fetch is in flight
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h040; #1;
        chk("rd0_req", bus.imem_req, 0);
        nxt(); bus.redirect_valid = 1'b0; #1;
        chk("rd1_req",   bus.imem_req,  1);
        chk("rd1_addr",  bus.imem_addr, 9'h040);
        chk("rd1_valid", bus.if_valid,  0);
        nxt(); #1;
        chk("rd2_valid", bus.if_valid,  0);
        chk("rd2_addr",  bus.imem_addr, 9'h044);
        nxt(); #1;
        chk("rd3_valid", bus.if_valid, 1);
        chk("rd3_pc",    bus.if_pc,    9'h040);
        chk("rd3_instr", bus.if_instr, word(9'h040));
        nxt(); #1;
        chk("rd4_pc",    bus.if_pc,    9'h044);

        // Redirect with coincident pop, then back-to-back 0x10 / 0x20
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h010; #1;
        chk("bb0_req", bus.imem_req, 0);
        nxt(); bus.redirect_pc = 9'h020; #1;
        chk("bb1_req",   bus.imem_req, 0);
        chk("bb1_valid", bus.if_valid, 0);
        nxt(); bus.redirect_valid = 1'b0; #1;
        chk("bb2_addr",  bus.imem_addr, 9'h020);
        chk("bb2_valid", bus.if_valid,  0);
        nxt(); #1;
        chk("bb3_valid", bus.if_valid, 0);
        nxt(); #1;
        chk("bb4_pc",    bus.if_pc, 9'h020);
        nxt(); #1;
        chk("bb5_pc",    bus.if_pc, 9'h024);

        // Redirect to the top of the address space: PC wraps
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h1FC;
        nxt(); bus.redirect_valid = 1'b0; #1;
        chk("wr1_addr", bus.imem_addr, 9'h1FC);
        nxt(); #1;
        chk("wr2_addr", bus.imem_addr, 9'h000);
        nxt(); #1;
        chk("wr3_pc",    bus.if_pc,      9'h1FC);
        chk("wr3_pc4",   bus.if_pcplus4, 9'h000);
        chk("wr3_instr", bus.if_instr,   word(9'h1FC));
        nxt(); #1;
        chk("wr4_pc",    bus.if_pc,      9'h000);
        chk("wr4_pc4",   bus.if_pcplus4, 9'h004);

        // Misaligned redirect target 0x42
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h042;
        nxt(); bus.redirect_valid = 1'b0; #1;
`ifdef IF_MISALIGN_TRAP_EN
        chk("ma1_fault", bus.if_fault, 1);
        chk("ma1_req",   bus.imem_req, 0);
        nxt(); #1;
        chk("ma2_req",   bus.imem_req, 0);
        nxt(); #1;
        chk("ma3_req",   bus.imem_req, 0);
        chk("ma3_valid", bus.if_valid, 0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 9'h040;
        nxt(); bus.redirect_valid = 1'b0; #1;
        chk("ma4_fault", bus.if_fault,  0);
        chk("ma4_req",   bus.imem_req,  1);
        chk("ma4_addr",  bus.imem_addr, 9'h040);
        nxt(); nxt(); #1;
        chk("ma6_pc",    bus.if_pc,     9'h040);
`else
        chk("ma1_req",   bus.imem_req,  1);
        chk("ma1_addr",  bus.imem_addr, 9'h040);
        nxt(); nxt(); #1;
        chk("ma3_valid", bus.if_valid,  1);
        chk("ma3_pc",    bus.if_pc,     9'h040);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
